// File: rtl/tone_gen.sv
// tone_gen: square-wave speaker drive from a full-period clock count.
// Period changes are only taken at period boundaries, so note changes and
// stops never truncate a pulse. A small PWM gates the high phase for volume.
module tone_gen #(
    parameter int CNT_W   = 21,
    parameter int MIN_DIV = 4,
    parameter int VOL_W   = 3
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [CNT_W-1:0] div_in,
    input  logic             enable,
    input  logic [VOL_W-1:0] vol,
    output logic             audio_out,
    output logic             period_done,
    output logic             active
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_half;
    logic [VOL_W-1:0] r_pwm;
    logic             r_audio;
    logic             r_done;
    logic             r_active;

    state_t           w_nextState;
    logic [CNT_W-1:0] w_nextCnt;
    logic [CNT_W-1:0] w_nextPeriod;
    logic [CNT_W-1:0] w_nextHalf;
    logic [VOL_W-1:0] w_nextPwm;
    logic             w_nextAudio;
    logic             w_nextDone;
    logic             w_nextActive;
    logic             w_start;
    logic             w_volFull;

    // A tone may only begin when enabled with a usable period; anything else is a rest.
    assign w_start   = enable && (div_in >= CNT_W'(MIN_DIV));
    assign w_volFull = (vol == {VOL_W{1'b1}});

    assign audio_out   = r_audio;
    assign period_done = r_done;
    assign active      = r_active;

    // Next-state logic; the outputs are derived from the upcoming state so
    // that once registered they line up exactly with the cycle they describe.
    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = r_cnt;
        w_nextPeriod = r_period;
        w_nextHalf   = r_half;
        w_nextPwm    = r_pwm + VOL_W'(1);
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_nextPeriod = div_in;
                    w_nextHalf   = div_in >> 1;
                    w_nextCnt    = '0;
                    w_nextPwm    = '0;
                    w_nextState  = HIGH;
                end
            end
            HIGH: begin
                w_nextCnt = r_cnt + CNT_W'(1);
                if (r_cnt == r_half - CNT_W'(1)) begin
                    w_nextState = LOW;
                end
            end
            LOW: begin
                if (r_cnt == r_period - CNT_W'(1)) begin
                    w_nextCnt = '0;
                    if (w_start) begin
                        w_nextPeriod = div_in;
                        w_nextHalf   = div_in >> 1;
                        w_nextPwm    = '0;
                        w_nextState  = HIGH;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else begin
                    w_nextCnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = '0;
            end
        endcase
        w_nextAudio  = (w_nextState == HIGH) && (w_volFull || (w_nextPwm < vol));
        w_nextDone   = (w_nextState == LOW) && (w_nextCnt == w_nextPeriod - CNT_W'(1));
        w_nextActive = (w_nextState != IDLE);
    end

    // State, counters, latched period and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset_) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_half   <= '0;
            r_pwm    <= '0;
            r_audio  <= 1'b0;
            r_done   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_cnt    <= w_nextCnt;
            r_period <= w_nextPeriod;
            r_half   <= w_nextHalf;
            r_pwm    <= w_nextPwm;
            r_audio  <= w_nextAudio;
            r_done   <= w_nextDone;
            r_active <= w_nextActive;
        end
    end

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: directed scoreboard bench for tone_gen.
// Expected {audio_out, period_done, active} per cycle are queued as stimulus
// is applied and popped one per clock as the DUT produces output.
module tb_tone_gen;

    logic        clk = 1'b0;
    logic        reset_;
    logic        enable;
    logic [20:0] div_in;
    logic [2:0]  vol;
    logic        audio_out;
    logic        period_done;
    logic        active;

    int          checks    = 0;
    int          errors    = 0;
    int          audioOnes = 0;
    logic [2:0]  expQ[$];

    tone_gen #(.CNT_W(21), .MIN_DIV(4), .VOL_W(3)) dut (
        .clk         (clk),
        .reset_      (reset_),
        .div_in      (div_in),
        .enable      (enable),
        .vol         (vol),
        .audio_out   (audio_out),
        .period_done (period_done),
        .active      (active)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic en, input int p, input int v);
        reset_ = r;
        enable = en;
        div_in = 21'(p);
        vol    = 3'(v);
    endtask

    // Queue cycles first..first+count-1 of a tone period of length p at volume v.
    task automatic pushTone(input int p, input int v, input int first, input int count);
        int   h;
        int   pwm;
        logic hi;
        logic aud;
        logic done;
        h = p / 2;
        for (int c = first; c < first + count; c++) begin
            hi   = (c < h);
            pwm  = c % 8;
            aud  = hi && ((v == 7) || (pwm < v));
            done = (c == p - 1);
            expQ.push_back({aud, done, 1'b1});
        end
    endtask

    task automatic pushIdle(input int n);
        for (int i = 0; i < n; i++) begin
            expQ.push_back(3'b000);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [2:0] obs;
        logic [2:0] exp;
        obs = {audio_out, period_done, active};
        if (audio_out === 1'b1) audioOnes++;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed %b", tag, obs);
        end else begin
            exp = expQ.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s {audio,done,active} observed %b expected %b", tag, obs, exp);
            end
        end
    endtask

    task automatic runCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            checkOutput($sformatf("%s[%0d]", tag, i));
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 0, 0);
        pushIdle(2);
        runCycles(2, "reset");

        applyStimulus(1'b0, 1'b1, 10, 7);
        pushTone(10, 7, 0, 10);
        pushTone(10, 7, 0, 10);
        pushTone(10, 7, 0, 10);
        runCycles(30, "basic10");

        applyStimulus(1'b0, 1'b1, 11, 7);
        pushTone(11, 7, 0, 11);
        pushTone(11, 7, 0, 11);
        runCycles(22, "odd11");

        applyStimulus(1'b0, 1'b1, 10, 7);
        pushTone(10, 7, 0, 10);
        runCycles(4, "chg10a");
        applyStimulus(1'b0, 1'b1, 20, 7);
        runCycles(6, "chg10b");
        pushTone(20, 7, 0, 20);
        runCycles(20, "chg20");

        applyStimulus(1'b0, 1'b1, 10, 7);
        pushTone(10, 7, 0, 10);
        pushIdle(3);
        runCycles(3, "noteoffA");
        applyStimulus(1'b0, 1'b0, 10, 7);
        runCycles(10, "noteoffB");

        applyStimulus(1'b0, 1'b1, 3, 7);
        pushIdle(5);
        runCycles(5, "rest3");

        applyStimulus(1'b0, 1'b1, 100, 7);
        pushTone(100, 7, 0, 60);
        runCycles(60, "p100");
        applyStimulus(1'b1, 1'b1, 100, 7);
        pushIdle(1);
        runCycles(1, "midreset");
        applyStimulus(1'b0, 1'b1, 100, 7);
        pushTone(100, 7, 0, 8);
        runCycles(8, "restart");
        applyStimulus(1'b1, 1'b0, 0, 7);
        pushIdle(1);
        runCycles(1, "reset2");
        applyStimulus(1'b0, 1'b0, 0, 7);
        pushIdle(2);
        runCycles(2, "idle2");

        applyStimulus(1'b0, 1'b1, 64, 4);
        pushTone(64, 4, 0, 64);
        audioOnes = 0;
        runCycles(64, "vol4");
        checks++;
        assert (audioOnes == 16) else begin
            errors++;
            $error("FAIL vol4_ones observed %0d expected 16", audioOnes);
        end

        applyStimulus(1'b0, 1'b1, 64, 0);
        pushTone(64, 0, 0, 64);
        runCycles(1, "vol0a");
        applyStimulus(1'b0, 1'b0, 64, 0);
        runCycles(63, "vol0b");
        pushIdle(2);
        runCycles(2, "vol0idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
